seg_unscan: RTL and testbench
=============================

# seg_unscan

Display-side capture block: samples the multiplexed seven-segment bus (active-low digit selects plus shared segment data) and rebuilds a static per-digit image. It rejects ghosting during select transitions by requiring a stable dwell, decodes each digit to a hex value, and flags complete frames. It sits at the far end of the scanned display interface and serves as a bench monitor and self-check observer for the display path.

## Interface
- `DIGITS`, 6: number of scanned digits. Range 1..8.
- `STABLE_CNT`, 4: number of consecutive identical samples required before a digit is latched. Range 2..255.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset. Synchronous and active-high.
- `seg_sel_n` in DIGITS: digit selects, active low. Bit i selects digit i.
- `seg_data` in 8: segment data, active high. Bit 0 = a, bit 6 = g, bit 7 = dp.
- `digit_code` out 8*DIGITS: latched raw segment byte per digit. Digit i occupies [8i+7:8i].
- `digit_val` out 4*DIGITS: decoded hex value per digit.
- `digit_known` out DIGITS: 1 when that digit's bits [6:0] match the hex table.
- `digit_valid` out DIGITS: 1 once the digit has been latched since reset.
- `frame_done` out 1: one-cycle pulse when every digit has been latched since the previous pulse.
- `sel_err` out 1: one-cycle pulse per sampled cycle with more than one select low.

## Operation
- Input stage:
  - `r_sel` and `r_data` register the pins every cycle.
  - Reset values: `r_sel` all ones, `r_data` 0.
- Sample classes, evaluated on the pins:
  - **idle**: no select low.
  - **one-hot**: exactly one select low; index i.
  - **multi**: two or more selects low.
- Dwell counter `cnt`, width 8. On each edge:
  - If the pins are one-hot and equal `r_sel`/`r_data`: `cnt <= min(cnt+1, STABLE_CNT-1)`.
  - Otherwise: `cnt <= 0`.
- Latch rule:
  - Fires on the edge where `cnt` goes from STABLE_CNT-2 to STABLE_CNT-1.
  - Writes `r_data` into digit i of `digit_code`, updates `digit_val[i]` and `digit_known[i]`, and sets `digit_valid[i]`.
  - Fires once per dwell. While `cnt` stays saturated there is no re-latch; a new latch needs a change in select or data.
- Decode uses bits [6:0] only; dp is ignored.
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Any other pattern gives val 0 and known 0. This includes blank 00 and the direction symbols.
- Frame tracking:
  - `seen` register, DIGITS bits, set per latch.
  - When the latch would complete `seen` to all ones, `frame_done` pulses and `seen` clears on that same edge.
  - A re-latch of an already-seen digit does not advance the frame.
- `sel_err` is registered high for one cycle per multi sample. A multi sample also resets `cnt`.
- Idle and multi samples never latch.

## Timing
- Latch latency:
  - New pin values are first present before edge 0 and held.
  - `digit_*` outputs update after edge STABLE_CNT-1, i.e. on the STABLE_CNT-th edge to see the value.
  - Example: 4 edges at the default.
- `frame_done` asserts in the same cycle the final digit's outputs update, for exactly one cycle.
- `sel_err` asserts in the cycle after the edge that sampled the multi pattern.
- Reset, effective on the edge where `rst` = 1:
  - All outputs 0: `digit_code`, `digit_val`, `digit_known`, `digit_valid`, `frame_done`, `sel_err`.
  - Internal state cleared: `cnt` = 0, `seen` = 0, input registers return to their reset values.
- Reset mid-dwell aborts the pending latch. After release, a full STABLE_CNT samples are needed again.
- Reset has priority over all updates in the same cycle.

## Test plan
1. **Reset**: hold `rst` for 2 cycles with arbitrary pins -> all outputs 0. Afterwards, sel_n = 111111 for 10 cycles -> outputs stay 0.
2. **Single latch and short dwell**: sel_n = 111110, data = 06 for 4 cycles -> after the 4th edge `digit_code[7:0]` = 06, `digit_val[3:0]` = 1, `digit_known[0]` = 1, `digit_valid` = 000001. Then a 3-cycle dwell of sel_n = 111101, data = 5B -> no change to digit 1.
3. **Full frame**: scan digits 0..5 with 3F, 06, 5B, 4F, 66, 6D, each held 5 cycles, with 1 idle cycle between digits -> `digit_val` = 24'h543210, `digit_known` = 111111. Exactly one `frame_done` pulse, in the cycle digit 5 updates. Repeat the scan -> exactly one more pulse.
4. **Multi-select**: sel_n = 111100 for 6 cycles -> `sel_err` high for 6 consecutive cycles and nothing latched. Then 3 cycles of one-hot -> still no latch.
5. **Unknown patterns and dp**:
   - data = C0 on digit 2 -> `digit_code` byte 2 = C0, known[2] = 0, val = 0.
   - data = BF on digit 3 -> known[3] = 1, val = 0.
   - data = 71 -> val = F.
6. **Reset mid-dwell**: assert `rst` after 2 cycles of a stable digit 0 dwell, then release with the pins still held -> the latch occurs exactly 4 edges after release, not earlier.

Source files
------------

// File: rtl/seg_unscan.sv
// seg_unscan: rebuilds a static per-digit image from a multiplexed
// seven-segment bus. A digit is latched after a stable one-hot dwell.
// Each latched digit is decoded to hex, and complete frames are flagged.

// One digit slot: holds the latched raw byte and its hex decode.
module seg_unscan_lane (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] data,
    output logic [7:0] code,
    output logic [3:0] val,
    output logic       known,
    output logic       valid
);

    // Decode bits [6:0] to {known, val}. The dp bit is ignored.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F: decode = {1'b1, 4'h0};
            7'h06: decode = {1'b1, 4'h1};
            7'h5B: decode = {1'b1, 4'h2};
            7'h4F: decode = {1'b1, 4'h3};
            7'h66: decode = {1'b1, 4'h4};
            7'h6D: decode = {1'b1, 4'h5};
            7'h7D: decode = {1'b1, 4'h6};
            7'h07: decode = {1'b1, 4'h7};
            7'h7F: decode = {1'b1, 4'h8};
            7'h6F: decode = {1'b1, 4'h9};
            7'h77: decode = {1'b1, 4'hA};
            7'h7C: decode = {1'b1, 4'hB};
            7'h39: decode = {1'b1, 4'hC};
            7'h5E: decode = {1'b1, 4'hD};
            7'h79: decode = {1'b1, 4'hE};
            7'h71: decode = {1'b1, 4'hF};
            default: decode = 5'h00;
        endcase
    endfunction

    logic [4:0] dec;
    assign dec = decode(data[6:0]);

    // Capture the byte and its decode when this digit's dwell completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            code  <= '0;
            val   <= '0;
            known <= 1'b0;
            valid <= 1'b0;
        end else if (wr_en) begin
            code  <= data;
            val   <= dec[3:0];
            known <= dec[4];
            valid <= 1'b1;
        end
    end

endmodule

module seg_unscan #(
    parameter int DIGITS     = 6,
    parameter int STABLE_CNT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     seg_sel_n,
    input  logic [7:0]            seg_data,
    output logic [8*DIGITS-1:0]   digit_code,
    output logic [4*DIGITS-1:0]   digit_val,
    output logic [DIGITS-1:0]     digit_known,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  frame_done,
    output logic                  sel_err
);

    // The counter saturates at CNT_MAX. Arriving there from CNT_ARM is the single latch point.
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CNT - 1);
    localparam logic [7:0] CNT_ARM = 8'(STABLE_CNT - 2);

    logic [DIGITS-1:0] r_sel;
    logic [7:0]        r_data;
    logic [7:0]        cnt;
    logic [DIGITS-1:0] seen;

    logic [DIGITS-1:0] sel;
    logic              one_hot;
    logic              multi;
    logic              stable;
    logic              latch;
    logic [DIGITS-1:0] wr_en;
    logic [DIGITS-1:0] seen_nxt;
    logic              complete;

    logic [DIGITS-1:0][7:0] lane_code;
    logic [DIGITS-1:0][3:0] lane_val;

    // Classify the raw pins and decide whether this edge latches a digit.
    always_comb begin
        sel      = ~seg_sel_n;
        one_hot  = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
        multi    = (sel != '0) && !one_hot;
        stable   = one_hot && (seg_sel_n == r_sel) && (seg_data == r_data);
        latch    = stable && (cnt == CNT_ARM);
        wr_en    = latch ? sel : '0;
        seen_nxt = seen | wr_en;
        complete = latch && (&seen_nxt);
    end

    // Input registers, dwell counter, frame tracking and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel      <= '1;
            r_data     <= '0;
            cnt        <= '0;
            seen       <= '0;
            frame_done <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            r_sel      <= seg_sel_n;
            r_data     <= seg_data;
            if (stable)
                cnt <= (cnt == CNT_MAX) ? cnt : cnt + 8'd1;
            else
                cnt <= '0;
            seen       <= complete ? '0 : seen_nxt;
            frame_done <= complete;
            sel_err    <= multi;
        end
    end

    // The latched byte equals the pins on a stable edge, so r_data is written.
    for (genvar i = 0; i < DIGITS; i++) begin : g_lane
        seg_unscan_lane u_lane (
            .clk   (clk),
            .rst   (rst),
            .wr_en (wr_en[i]),
            .data  (r_data),
            .code  (lane_code[i]),
            .val   (lane_val[i]),
            .known (digit_known[i]),
            .valid (digit_valid[i])
        );
    end

    assign digit_code = lane_code;
    assign digit_val  = lane_val;

endmodule

// File: tb/tb_seg_unscan.sv
// Randomized + directed bench for seg_unscan against a run-length model.
module tb_seg_unscan;

    localparam int DIGITS     = 6;
    localparam int STABLE_CNT = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [DIGITS-1:0]   sel_n = '1;
    logic [7:0]          dat = '0;
    logic [8*DIGITS-1:0] digit_code;
    logic [4*DIGITS-1:0] digit_val;
    logic [DIGITS-1:0]   digit_known;
    logic [DIGITS-1:0]   digit_valid;
    logic                frame_done;
    logic                sel_err;

    seg_unscan #(.DIGITS(DIGITS), .STABLE_CNT(STABLE_CNT)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_sel_n   (sel_n),
        .seg_data    (dat),
        .digit_code  (digit_code),
        .digit_val   (digit_val),
        .digit_known (digit_known),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .sel_err     (sel_err)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_seen = 0;
    int err_seen = 0;

    logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    // Reference model: a digit is captured when the same one-hot sample has
    // been seen on exactly STABLE_CNT consecutive edges.
    int                run;
    logic [DIGITS-1:0] p_sel;
    logic [7:0]        p_data;
    logic [7:0]        m_code [DIGITS];
    logic [3:0]        m_val  [DIGITS];
    logic [DIGITS-1:0] m_known, m_valid, m_seen;
    logic              m_fd, m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input logic r, input logic [DIGITS-1:0] s, input logic [7:0] d);
        int nlow;
        int idx;
        nlow = $countones(~s);
        if (r) begin
            run = 0; p_sel = '1; p_data = '0;
            for (int k = 0; k < DIGITS; k++) begin m_code[k] = '0; m_val[k] = '0; end
            m_known = '0; m_valid = '0; m_seen = '0; m_fd = 0; m_err = 0;
        end else begin
            if (nlow == 1 && s == p_sel && d == p_data) run++;
            else run = (nlow == 1) ? 1 : 0;
            p_sel = s; p_data = d;
            m_err = (nlow >= 2);
            m_fd  = 0;
            if (run == STABLE_CNT) begin
                idx = 0;
                for (int k = 0; k < DIGITS; k++) if (!s[k]) idx = k;
                m_code[idx]  = d;
                m_val[idx]   = 0;
                m_known[idx] = 0;
                for (int k = 0; k < 16; k++)
                    if (hex_tab[k][6:0] == d[6:0]) begin m_val[idx] = 4'(k); m_known[idx] = 1; end
                m_valid[idx] = 1;
                m_seen[idx]  = 1;
                if (&m_seen) begin m_fd = 1; m_seen = '0; end
            end
        end
    endtask

    task automatic compare_all();
        logic [8*DIGITS-1:0] ec;
        logic [4*DIGITS-1:0] ev;
        for (int k = 0; k < DIGITS; k++) begin
            ec[8*k +: 8] = m_code[k];
            ev[4*k +: 4] = m_val[k];
        end
        chk("code",  64'(digit_code),  64'(ec));
        chk("val",   64'(digit_val),   64'(ev));
        chk("known", 64'(digit_known), 64'(m_known));
        chk("valid", 64'(digit_valid), 64'(m_valid));
        chk("frame", 64'(frame_done),  64'(m_fd));
        chk("selerr",64'(sel_err),     64'(m_err));
    endtask

    // Drive one cycle, advance the model on the edge, check just after it.
    task automatic cyc(input logic r, input logic [DIGITS-1:0] s, input logic [7:0] d);
        rst = r; sel_n = s; dat = d;
        @(posedge clk);
        model(r, s, d);
        #1;
        if (frame_done) fd_seen++;
        if (sel_err) err_seen++;
        compare_all();
    endtask

    task automatic hold(input logic [DIGITS-1:0] s, input logic [7:0] d, input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, s, d);
    endtask

    initial begin
        int f0;
        logic [DIGITS-1:0] rs;
        logic [7:0] rd;
        model(1'b1, '1, '0);

        // Reset with arbitrary pins, then idle.
        cyc(1'b1, DIGITS'($urandom), 8'($urandom));
        cyc(1'b1, DIGITS'($urandom), 8'($urandom));
        chk("rst_code",  64'(digit_code), 64'h0);
        chk("rst_valid", 64'(digit_valid), 64'h0);
        hold('1, 8'h00, 10);
        chk("idle_valid", 64'(digit_valid), 64'h0);

        // Single latch, then a dwell one cycle short.
        hold(6'b111110, 8'h06, 3);
        chk("pre_latch", 64'(digit_valid), 64'h0);
        hold(6'b111110, 8'h06, 1);
        chk("t2_code0",  64'(digit_code[7:0]), 64'h06);
        chk("t2_val0",   64'(digit_val[3:0]),  64'h1);
        chk("t2_known0", 64'(digit_known[0]),  64'h1);
        chk("t2_valid",  64'(digit_valid),     64'b000001);
        hold(6'b111101, 8'h5B, 3);
        chk("t2_short",  64'(digit_valid),     64'b000001);

        // Full frame scans, twice.
        for (int rep = 0; rep < 2; rep++) begin
            f0 = fd_seen;
            for (int d = 0; d < DIGITS; d++) begin
                hold(~DIGITS'(1 << d), hex_tab[d], 5);
                hold('1, 8'h00, 1);
            end
            chk("t3_val",    64'(digit_val),   64'h543210);
            chk("t3_known",  64'(digit_known), 64'h3F);
            chk("t3_frames", 64'(fd_seen - f0), 64'd1);
        end

        // Multi-select, then a short one-hot dwell.
        f0 = err_seen;
        hold(6'b111100, 8'h55, 6);
        chk("t4_errcnt", 64'(err_seen - f0), 64'd6);
        hold(6'b111011, 8'h66, 3);
        chk("t4_code2",  64'(digit_code[23:16]), 64'h5B);

        // Unknown patterns and the dp bit.
        hold(6'b111011, 8'hC0, 4);
        chk("t5_code2",  64'(digit_code[23:16]), 64'hC0);
        chk("t5_known2", 64'(digit_known[2]),    64'h0);
        chk("t5_val2",   64'(digit_val[11:8]),   64'h0);
        hold(6'b110111, 8'hBF, 4);
        chk("t5_known3", 64'(digit_known[3]),    64'h1);
        chk("t5_val3",   64'(digit_val[15:12]),  64'h0);
        hold(6'b101111, 8'h71, 4);
        chk("t5_val4",   64'(digit_val[19:16]),  64'hF);

        // Reset mid-dwell: latch needs a full dwell after release.
        hold(6'b111110, 8'h4F, 2);
        cyc(1'b1, 6'b111110, 8'h4F);
        hold(6'b111110, 8'h4F, 3);
        chk("t6_early",  64'(digit_valid),    64'h0);
        hold(6'b111110, 8'h4F, 1);
        chk("t6_code0",  64'(digit_code[7:0]), 64'h4F);

        // Randomized traffic: mostly one-hot dwells with glitches and resets.
        for (int seg = 0; seg < 700; seg++) begin
            case ($urandom_range(0, 9))
                0:       rs = '1;
                1:       rs = DIGITS'($urandom);
                default: rs = ~DIGITS'(1 << $urandom_range(0, DIGITS - 1));
            endcase
            rd = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (hex_tab[$urandom_range(0, 15)] | 8'($urandom_range(0, 1) << 7));
            if ($urandom_range(0, 60) == 0) cyc(1'b1, rs, rd);
            hold(rs, rd, $urandom_range(1, 7));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
